// File: rtl/strobe_mode_ctrl_pkg.sv
// Shared definitions for the LED strobe mode sequencer: state encoding,
// mode count and the index-to-one-hot helper used for the select output.
package strobe_pkg;

  localparam int NUM_MODES = 4;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/strobe_mode_ctrl_dwell_timer.sv
// Dwell timer for the auto-cycle mode. Counts while enabled, flags the
// cycle on which the count reaches DWELL_CYCLES-1 and restarts from 0.
// Held at 0 while disabled; clr forces a restart from 0.
module dwell_timer #(
  parameter int CNT_W        = 24,
  parameter int DWELL_CYCLES = 12_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign expire = en && (cnt == LAST);

  // Count up while enabled; restart on clear, on expiry, or when disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || clr || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/strobe_mode_ctrl.sv
// Mode sequencer for the LED strobe generator. Takes debounced one-cycle
// button pulses and drives a registered one-hot mode select, with manual
// stepping and a timed auto-cycle mode.
// Optional build macro STROBE_CTRL_BOUNCE_EN: auto-cycle ping-pongs
// 0,1,2,3,2,1,0,... instead of wrapping 3->0.
//
// Button handshake: each btn_* input is a single-cycle pulse sampled on the
// rising clock edge; there is no ready/backpressure, every pulse is consumed
// the cycle it is seen and its effect is visible on the outputs after that
// same edge. Priority: btn_off > btn_run > btn_next/btn_prev; next and prev
// together cancel each other.
module strobe_mode_ctrl
  import strobe_pkg::*;
#(
  parameter int DWELL_CYCLES = 12_000_000,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_run,
  input  logic       btn_off,
  output logic [3:0] select,
  output logic [1:0] mode_idx,
  output logic       auto_active
);

  state_t     state, nxt_state;
  logic [1:0] idx, nxt_idx;
  logic       step;
  logic       expire;
  logic       timer_en;
  logic       timer_clr;

  assign step      = btn_next ^ btn_prev;
  assign timer_en  = (state == ST_AUTO);
  assign timer_clr = btn_off | btn_run | step;

  dwell_timer #(
    .CNT_W        (CNT_W),
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .en     (timer_en),
    .clr    (timer_clr),
    .expire (expire)
  );

`ifdef STROBE_CTRL_BOUNCE_EN
  logic dir_up, nxt_dir_up;
`endif

  // Next-state and next-index decision, in button priority order.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
`ifdef STROBE_CTRL_BOUNCE_EN
    nxt_dir_up = dir_up;
`endif
    if (btn_off) begin
      nxt_state = ST_OFF;
    end else if (btn_run) begin
      if (state == ST_AUTO) begin
        nxt_state = ST_MANUAL;
      end else begin
        nxt_state = ST_AUTO;
        if (state == ST_OFF) nxt_idx = 2'd0;
`ifdef STROBE_CTRL_BOUNCE_EN
        nxt_dir_up = 1'b1;
`endif
      end
    end else if (step) begin
      if (state == ST_OFF) begin
        nxt_state = ST_MANUAL;
        nxt_idx   = btn_next ? 2'd0 : 2'd3;
      end else begin
        nxt_idx = btn_next ? idx + 2'd1 : idx - 2'd1;
      end
    end else if (expire) begin
`ifdef STROBE_CTRL_BOUNCE_EN
      // Reversal is decided at advance time, so a manual landing on an
      // end point turns around on the next timed advance.
      if (dir_up) begin
        if (idx == 2'd3) begin
          nxt_idx    = 2'd2;
          nxt_dir_up = 1'b0;
        end else begin
          nxt_idx = idx + 2'd1;
        end
      end else begin
        if (idx == 2'd0) begin
          nxt_idx    = 2'd1;
          nxt_dir_up = 1'b1;
        end else begin
          nxt_idx = idx - 2'd1;
        end
      end
`else
      nxt_idx = idx + 2'd1;
`endif
    end
  end

  // State, index and registered outputs; index is kept in OFF but masked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_OFF;
      idx         <= 2'd0;
      select      <= 4'b0000;
      mode_idx    <= 2'd0;
      auto_active <= 1'b0;
    end else begin
      state       <= nxt_state;
      idx         <= nxt_idx;
      select      <= (nxt_state == ST_OFF) ? 4'b0000 : idx_to_onehot(nxt_idx);
      mode_idx    <= (nxt_state == ST_OFF) ? 2'd0 : nxt_idx;
      auto_active <= (nxt_state == ST_AUTO);
    end
  end

`ifdef STROBE_CTRL_BOUNCE_EN
  // Auto-cycle direction flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_up <= 1'b1;
    end else begin
      dir_up <= nxt_dir_up;
    end
  end
`endif

endmodule

// File: doc/strobe_mode_ctrl.md
Name: strobe_mode_ctrl

Overview:
- Sequencer that drives the one-hot 4-bit mode select of the LED strobe generator.
- Takes single-cycle, already-debounced button pulses; supports manual stepping and an auto-cycle mode that advances the mode after a programmable dwell time.
- Sits between the button debouncers and the strobe block on the icefun top level.

Parameters:
- DWELL_CYCLES, 12_000_000, clock cycles spent in each mode during auto-cycle (1 s at 12 MHz); legal range 1 .. 2^CNT_W-1.
- CNT_W, 24, width of the dwell counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- btn_next  input  1  one-cycle pulse: step to next mode
- btn_prev  input  1  one-cycle pulse: step to previous mode
- btn_run  input  1  one-cycle pulse: toggle between MANUAL and AUTO
- btn_off  input  1  one-cycle pulse: go to OFF
- select  output  4  one-hot mode select to the strobe; 0 when OFF
- mode_idx  output  2  current mode index 0..3
- auto_active  output  1  high while in AUTO

Behaviour:
- Reset (reset=0, asynchronous): state=OFF, select=4'b0000, mode_idx=0, auto_active=0, dwell counter=0, direction=up. Reset held mid-operation aborts immediately; on release, operation resumes from OFF.
- All outputs are registered. A pulse sampled at edge N is reflected on the outputs after edge N (1-cycle latency).
- select = 4'b0001 << mode_idx in MANUAL/AUTO; 4'b0000 in OFF. select never has more than one bit set.
- Input priority per cycle: btn_off > btn_run > btn_next/btn_prev.
- btn_next and btn_prev asserted together cancel: no step, no dwell clear.
- States:
  - OFF:
    - btn_next -> MANUAL, idx=0.
    - btn_prev -> MANUAL, idx=3.
    - btn_run -> AUTO, idx=0, dwell=0.
  - MANUAL:
    - btn_next: idx+1, wrapping 3->0.
    - btn_prev: idx-1, wrapping 0->3.
    - btn_run -> AUTO, idx kept, dwell=0, direction=up.
    - btn_off -> OFF.
  - AUTO:
    - dwell counter increments every cycle.
    - When dwell == DWELL_CYCLES-1: advance idx (3->0 wrap), dwell=0.
    - btn_next/btn_prev step idx as in MANUAL and clear dwell.
    - btn_run -> MANUAL, idx kept.
    - btn_off -> OFF.
- Dwell counter is held at 0 outside AUTO.
- DWELL_CYCLES=1: idx advances every cycle in AUTO.
- A step from a button and a dwell expiry in the same cycle: apply the button step only; dwell clears.
- Unused mode_idx in OFF holds its last value internally but reads as 0 on the output.

Optional Feature:
- Macro: STROBE_CTRL_BOUNCE_EN.
- Defined: auto-cycle ping-pongs 0,1,2,3,2,1,0,1... using a direction flag.
  - Direction reverses on reaching 3 (going up) or 0 (going down).
  - Direction resets to up on reset and on every entry to AUTO.
  - Manual steps in AUTO do not change direction.
  - If a manual step lands on 3 while direction is up, the next auto advance goes to 2.
- Undefined: auto-cycle wraps 3->0. No direction register is built.

Decomposition:
- Package strobe_pkg:
  - State encoding localparams: ST_OFF=2'd0, ST_MANUAL=2'd1, ST_AUTO=2'd2.
  - NUM_MODES=4.
  - Function idx_to_onehot(2-bit) -> 4-bit.
- Sub-module dwell_timer (CNT_W, DWELL_CYCLES):
  - Inputs: clk, reset, en, clr.
  - Output: expire (high for the cycle the count equals DWELL_CYCLES-1).
  - Same reset style as the parent.

Test Plan:
- Reset then btn_next pulse -> one cycle later select=4'b0001, mode_idx=0, auto_active=0. Three more btn_next -> select=4'b1000. A fourth -> 4'b0001 (wrap).
- From OFF, btn_prev -> select=4'b1000. Simultaneous btn_next+btn_prev -> select unchanged.
- DWELL_CYCLES=4: btn_run from OFF -> auto_active=1, select steps 0001->0010->0100->1000->0001, each held exactly 4 cycles. With STROBE_CTRL_BOUNCE_EN, the sequence is 0001,0010,0100,1000,0100,0010,0001.
- AUTO with btn_next on dwell cycle 2 -> idx steps immediately and the next auto advance occurs 4 cycles later. btn_run+btn_off in the same cycle -> OFF, select=0.
- Assert reset mid-AUTO for 1 cycle, asynchronously between clock edges -> outputs go to 0 immediately. After release, stays OFF with no auto advance.
- DWELL_CYCLES=1 in AUTO -> select rotates every cycle. btn_run -> MANUAL, select freezes at the current value.
